time_base_counter: RTL
======================

Name: time_base_counter

Overview:
- Binary time-of-day counter for the VGA digital clock.
- Divides the system clock down to a 1 Hz tick and keeps hours/minutes/seconds as 6-bit binary values.
- Its outputs feed the binary-to-BCD converters directly, one converter per field (WIDTH_bin=6, WIDTH_bcd=8).
- Supports pause, per-field manual increment while paused, and a validated bulk-load handshake.

Parameters:
- CLK_FREQ, 50_000_000: system clock cycles per second; prescaler terminal count is CLK_FREQ-1; must be >= 2.
- PRE_W, $clog2(CLK_FREQ): prescaler width.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- run_en  input  1  1 = time advances; 0 = paused, manual increment allowed
- inc_pulse  input  1  single-cycle manual increment request
- inc_sel  input  2  increment target: 0 = sec, 1 = min, 2 = hour, 3 = none
- load_valid  input  1  bulk-load request
- load_hour  input  6  load value, hours
- load_min  input  6  load value, minutes
- load_sec  input  6  load value, seconds
- load_ready  output  1  load accepted when load_valid & load_ready
- load_err  output  1  1-cycle pulse: the accepted load was out of range and was discarded
- hour  output  6  current hour, 0..23 binary
- min  output  6  current minute, 0..59 binary
- sec  output  6  current second, 0..59 binary
- tick_1hz  output  1  1-cycle pulse in the cycle after the prescaler wraps
- day_wrap  output  1  1-cycle pulse when time rolls from 23:59:59 to 00:00:00

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-low: sampled only on the rising clk edge.
- Reset values:
  - hour = min = sec = 0; prescaler = 0.
  - tick_1hz = 0, day_wrap = 0, load_err = 0.
  - load_ready = 1; FSM = RUN_IDLE.
- Prescaler:
  - Counts only while run_en = 1.
  - Counts 0..CLK_FREQ-1, then wraps to 0. The wrap cycle raises an internal tick.
  - While run_en = 0 it holds its value; it does not clear.
- Time advance on internal tick (registered, visible 1 cycle after the wrap, together with tick_1hz):
  - sec increments; sec 59 -> 0 carries into min.
  - min 59 -> 0 carries into hour.
  - hour 23 -> 0 pulses day_wrap in the same cycle the outputs show 00:00:00.
- Manual increment:
  - Acts when inc_pulse = 1, run_en = 0 and no load is accepted that cycle.
  - Increments only the inc_sel field, modulo its range (sec/min wrap 59->0, hour wraps 23->0), with no carry and no day_wrap.
  - inc_sel = 3, or run_en = 1: ignored.
- Load handshake, FSM states RUN_IDLE and LOAD_BUSY:
  - RUN_IDLE: load_ready = 1. load_valid = 1 accepts the load and moves to LOAD_BUSY.
  - LOAD_BUSY: load_ready = 0 for exactly one cycle, then unconditional return to RUN_IDLE. load_valid is ignored here.
- On an accepted load, checked in the acceptance cycle:
  - All fields in range (hour <= 23, min <= 59, sec <= 59): outputs show the loaded values on the next cycle, the prescaler is cleared to 0, and no tick occurs in that cycle.
  - Any field out of range: time and prescaler are unchanged, and load_err pulses 1 cycle in the following cycle.
- Priority in a single cycle: reset > accepted load > internal tick > manual increment. A tick coinciding with an accepted load is dropped.
- All outputs are registered; no combinational input-to-output paths.
- Reset asserted mid-busy returns the FSM to RUN_IDLE with load_ready = 1 on the next cycle.

Test Plan (CLK_FREQ = 4):
- Reset, then run_en = 1 for 12 cycles -> tick_1hz pulses every 4th cycle; sec steps 0,1,2,3; min = hour = 0.
- Load 23:59:58 with run_en = 1 -> load_ready low for 1 cycle; 2 ticks later outputs show 00:00:00, day_wrap pulses for 1 cycle in that cycle, and min/hour wrap.
- Load hour = 24, min = 10, sec = 10 -> load_err pulses once; time unchanged; load_ready returns to 1 after 1 cycle.
- run_en = 0, inc_sel = 1, 3 inc_pulse from min = 58 -> min 59, 0, 1; hour unchanged; no tick_1hz; prescaler value held.
- inc_pulse with run_en = 1, or with inc_sel = 3 -> no change to any field.
- load_valid asserted in the same cycle as the prescaler wrap -> loaded value wins; no sec increment; next tick arrives 4 cycles after the load.

Source files
------------

// File: rtl/time_base_counter.sv
// Binary hh:mm:ss time base for the VGA clock: prescales clk to a 1 Hz tick,
// supports pause with per-field manual increment and a validated bulk load.
module time_base_counter #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned PRE_W    = $clog2(CLK_FREQ)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_en,
  input  logic       inc_pulse,
  input  logic [1:0] inc_sel,
  input  logic       load_valid,
  input  logic [5:0] load_hour,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  output logic       load_ready,
  output logic       load_err,
  output logic [5:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       tick_1hz,
  output logic       day_wrap
);

  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(CLK_FREQ - 1);
  localparam logic [5:0]       MAX_MS   = 6'd59;
  localparam logic [5:0]       MAX_HOUR = 6'd23;

  typedef enum logic {RUN_IDLE, LOAD_BUSY} state_t;

  state_t           r_state;
  logic [PRE_W-1:0] r_pre;
  logic [5:0]       r_hour, r_min, r_sec;
  logic             r_load_ready, r_load_err, r_tick, r_day_wrap;

  logic w_accept, w_load_ok, w_wrap, w_manual;

  // Load acceptance and range check share the same cycle; accepted loads block ticks and increments.
  assign w_accept  = (r_state == RUN_IDLE) && load_valid;
  assign w_load_ok = (load_hour <= MAX_HOUR) && (load_min <= MAX_MS) && (load_sec <= MAX_MS);
  assign w_wrap    = run_en && (r_pre == PRE_MAX);
  assign w_manual  = inc_pulse && !run_en && !w_accept;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= RUN_IDLE;
      r_pre        <= '0;
      r_hour       <= '0;
      r_min        <= '0;
      r_sec        <= '0;
      r_load_ready <= 1'b1;
      r_load_err   <= 1'b0;
      r_tick       <= 1'b0;
      r_day_wrap   <= 1'b0;
    end else begin
      r_tick     <= 1'b0;
      r_day_wrap <= 1'b0;
      r_load_err <= 1'b0;

      if (r_state == RUN_IDLE) begin
        if (load_valid) begin
          r_state      <= LOAD_BUSY;
          r_load_ready <= 1'b0;
        end
      end else begin
        r_state      <= RUN_IDLE;
        r_load_ready <= 1'b1;
      end

      if (w_accept) begin
        if (w_load_ok) begin
          r_hour <= load_hour;
          r_min  <= load_min;
          r_sec  <= load_sec;
          r_pre  <= '0;
        end else begin
          r_load_err <= 1'b1;
        end
      end else if (w_wrap) begin
        r_pre  <= '0;
        r_tick <= 1'b1;
        if (r_sec == MAX_MS) begin
          r_sec <= '0;
          if (r_min == MAX_MS) begin
            r_min <= '0;
            if (r_hour == MAX_HOUR) begin
              r_hour     <= '0;
              r_day_wrap <= 1'b1;
            end else begin
              r_hour <= r_hour + 6'd1;
            end
          end else begin
            r_min <= r_min + 6'd1;
          end
        end else begin
          r_sec <= r_sec + 6'd1;
        end
      end else begin
        if (run_en) begin
          r_pre <= r_pre + PRE_W'(1);
        end
        // Manual set: single field, modulo its range, no carry.
        if (w_manual) begin
          case (inc_sel)
            2'd0:    r_sec  <= (r_sec  == MAX_MS)   ? 6'd0 : r_sec  + 6'd1;
            2'd1:    r_min  <= (r_min  == MAX_MS)   ? 6'd0 : r_min  + 6'd1;
            2'd2:    r_hour <= (r_hour == MAX_HOUR) ? 6'd0 : r_hour + 6'd1;
            default: ;
          endcase
        end
      end
    end
  end

  assign load_ready = r_load_ready;
  assign load_err   = r_load_err;
  assign hour       = r_hour;
  assign min        = r_min;
  assign sec        = r_sec;
  assign tick_1hz   = r_tick;
  assign day_wrap   = r_day_wrap;

endmodule
